// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction memory request/response, redirect and decode handshake bundle
interface fetch_queue_if #(parameter int ADDR_W = 64);
  logic imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic imem_ack;
  logic [31:0] imem_rdata;
  logic redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic inst_valid;
  logic inst_ready;
  logic [31:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );
  modport slave (
    input imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with one outstanding request, PC/instruction FIFO and redirect flush
module fetch_queue #(
  parameter int ADDR_W = 64,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic reset,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  state_t state;
  logic [ADDR_W-1:0] fetch_pc, drop_addr;
  logic [ADDR_W+31:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic push, pop, room, valid;
  assign valid = count != '0;
  always_comb begin
    pop = valid & bus.inst_ready;
    push = (state == REQ) & bus.imem_ack & ~bus.redirect;
    count_next = count + CW'(push) - CW'(pop);
    room = count_next < FULL;
  end
  assign bus.imem_req = state != IDLE;
  assign bus.imem_addr = state == DROP ? drop_addr : fetch_pc;
  assign bus.inst_valid = valid;
  assign {bus.inst_pc, bus.inst} = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {fetch_pc, bus.imem_rdata};
  // A request is only issued when the slot it will fill is already known to be free.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      drop_addr <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (bus.redirect) begin
      state <= (state != IDLE && !bus.imem_ack) ? DROP : IDLE;
      if (state == REQ && !bus.imem_ack) drop_addr <= fetch_pc;
      fetch_pc <= bus.redirect_pc & ~ADDR_W'(3);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      count <= count_next;
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      state <= state == IDLE ? (room ? REQ : IDLE) :
               state == REQ ? ((!bus.imem_ack || room) ? REQ : IDLE) :
               (bus.imem_ack ? IDLE : DROP);
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios against a behavioural variable-latency instruction memory
module tb_fetch_queue;
  logic clk = 0;
  logic reset = 1;
  logic auto_mem = 1;
  logic man_ack = 0;
  int lat = 1;
  int wcnt = 0;
  int acks = 0;
  int pass = 0;
  int total = 0;
  fetch_queue_if #(.ADDR_W(64)) bus();
  fetch_queue #(.ADDR_W(64), .DEPTH(4), .RESET_PC(64'h0)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction
  assign bus.imem_ack = auto_mem ? (bus.imem_req && wcnt >= lat - 1) : man_ack;
  assign bus.imem_rdata = word(bus.imem_addr);
  always_ff @(posedge clk) begin
    wcnt <= (bus.imem_req && !bus.imem_ack) ? wcnt + 1 : 0;
    acks <= acks + ((bus.imem_req && bus.imem_ack) ? 1 : 0);
  end
  task automatic do_reset();
    reset = 1;
    bus.redirect = 0;
    bus.redirect_pc = '0;
    bus.inst_ready = 0;
    man_ack = 0;
    auto_mem = 1;
    lat = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask
  task automatic test_reset();
    reset = 1;
    bus.redirect = 0;
    bus.redirect_pc = '0;
    bus.inst_ready = 0;
    @(negedge clk);
    total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req got %0b want 0", bus.imem_req); else pass++;
    total++; if (bus.imem_addr !== 64'h0) $display("FAIL reset_addr got %h want 0", bus.imem_addr); else pass++;
    total++; if (bus.inst_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.inst_valid); else pass++;
    total++; if (bus.inst !== 32'h0) $display("FAIL reset_inst got %h want 0", bus.inst); else pass++;
    total++; if (bus.inst_pc !== 64'h0) $display("FAIL reset_pc got %h want 0", bus.inst_pc); else pass++;
  endtask
  task automatic test_stream();
    do_reset();
    bus.inst_ready = 1;
    @(negedge clk);
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) $display("FAIL stream_first req=%0b addr=%h want 1/0", bus.imem_req, bus.imem_addr); else pass++;
    total++; if (bus.inst_valid !== 1'b0) $display("FAIL stream_first_valid got %0b want 0", bus.inst_valid); else pass++;
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      total++; if (bus.imem_addr !== 64'(4 * (c - 1))) $display("FAIL stream_addr c%0d got %h want %h", c, bus.imem_addr, 4 * (c - 1)); else pass++;
      total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'(4 * (c - 2))) $display("FAIL stream_pc c%0d valid=%0b pc=%h want 1/%h", c, bus.inst_valid, bus.inst_pc, 4 * (c - 2)); else pass++;
      total++; if (bus.inst !== word(64'(4 * (c - 2)))) $display("FAIL stream_inst c%0d got %h want %h", c, bus.inst, word(64'(4 * (c - 2)))); else pass++;
    end
  endtask
  task automatic test_full();
    int a0;
    do_reset();
    a0 = acks;
    repeat (8) @(negedge clk);
    total++; if (acks - a0 !== 4) $display("FAIL full_acks got %0d want 4", acks - a0); else pass++;
    total++; if (bus.imem_req !== 1'b0) $display("FAIL full_req got %0b want 0", bus.imem_req); else pass++;
    total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h0) $display("FAIL full_head valid=%0b pc=%h want 1/0", bus.inst_valid, bus.inst_pc); else pass++;
    bus.inst_ready = 1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'(4 * k)) $display("FAIL drain_pc k%0d valid=%0b pc=%h want 1/%h", k, bus.inst_valid, bus.inst_pc, 4 * k); else pass++;
      if (k == 1) begin
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h10) $display("FAIL resume req=%0b addr=%h want 1/10", bus.imem_req, bus.imem_addr); else pass++;
      end
    end
  endtask
  task automatic test_latency();
    do_reset();
    lat = 3;
    bus.inst_ready = 1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      total++; if (bus.imem_addr !== 64'(4 * ((c - 1) / 3)) || bus.imem_req !== 1'b1) $display("FAIL lat_addr c%0d req=%0b addr=%h want 1/%h", c, bus.imem_req, bus.imem_addr, 4 * ((c - 1) / 3)); else pass++;
      total++; if (bus.inst_valid !== (c >= 4 && (c - 1) % 3 == 0)) $display("FAIL lat_valid c%0d got %0b", c, bus.inst_valid); else pass++;
      if (c >= 4 && (c - 1) % 3 == 0) begin
        total++; if (bus.inst_pc !== 64'(4 * ((c - 4) / 3))) $display("FAIL lat_pc c%0d got %h want %h", c, bus.inst_pc, 4 * ((c - 4) / 3)); else pass++;
      end
    end
  endtask
  task automatic test_drop();
    do_reset();
    auto_mem = 0;
    bus.inst_ready = 1;
    repeat (2) @(negedge clk);
    bus.redirect = 1;
    bus.redirect_pc = 64'h1003;
    @(negedge clk);
    bus.redirect = 0;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) $display("FAIL drop_hold req=%0b addr=%h want 1/0", bus.imem_req, bus.imem_addr); else pass++;
    total++; if (bus.inst_valid !== 1'b0) $display("FAIL drop_valid got %0b want 0", bus.inst_valid); else pass++;
    @(negedge clk);
    total++; if (bus.imem_addr !== 64'h0) $display("FAIL drop_hold2 got %h want 0", bus.imem_addr); else pass++;
    man_ack = 1;
    @(negedge clk);
    man_ack = 0;
    total++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) $display("FAIL drop_discard req=%0b valid=%0b want 0/0", bus.imem_req, bus.inst_valid); else pass++;
    @(negedge clk);
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h1000) $display("FAIL drop_newreq req=%0b addr=%h want 1/1000", bus.imem_req, bus.imem_addr); else pass++;
    man_ack = 1;
    @(negedge clk);
    man_ack = 0;
    total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h1000) $display("FAIL drop_pc valid=%0b pc=%h want 1/1000", bus.inst_valid, bus.inst_pc); else pass++;
    total++; if (bus.inst !== word(64'h1000)) $display("FAIL drop_inst got %h want %h", bus.inst, word(64'h1000)); else pass++;
  endtask
  task automatic test_redirect_ack_pop();
    do_reset();
    auto_mem = 0;
    man_ack = 1;
    repeat (3) @(negedge clk);
    total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h0 || bus.imem_addr !== 64'h8) $display("FAIL rap_setup valid=%0b pc=%h addr=%h want 1/0/8", bus.inst_valid, bus.inst_pc, bus.imem_addr); else pass++;
    bus.inst_ready = 1;
    bus.redirect = 1;
    bus.redirect_pc = 64'h2000;
    @(negedge clk);
    bus.redirect = 0;
    man_ack = 0;
    total++; if (bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 || bus.inst_pc !== 64'h0) $display("FAIL rap_flush valid=%0b inst=%h pc=%h want 0/0/0", bus.inst_valid, bus.inst, bus.inst_pc); else pass++;
    total++; if (bus.imem_req !== 1'b0) $display("FAIL rap_idle got %0b want 0", bus.imem_req); else pass++;
    @(negedge clk);
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h2000) $display("FAIL rap_newreq req=%0b addr=%h want 1/2000", bus.imem_req, bus.imem_addr); else pass++;
    man_ack = 1;
    @(negedge clk);
    man_ack = 0;
    total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h2000) $display("FAIL rap_pc valid=%0b pc=%h want 1/2000", bus.inst_valid, bus.inst_pc); else pass++;
  endtask
  task automatic test_wrap_async_reset();
    do_reset();
    bus.inst_ready = 1;
    @(negedge clk);
    bus.redirect = 1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    bus.redirect = 0;
    total++; if (bus.imem_req !== 1'b0) $display("FAIL wrap_idle got %0b want 0", bus.imem_req); else pass++;
    @(negedge clk);
    total++; if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_top got %h want fffffffffffffffc", bus.imem_addr); else pass++;
    @(negedge clk);
    total++; if (bus.imem_addr !== 64'h0 || bus.inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_zero addr=%h pc=%h want 0/fffffffffffffffc", bus.imem_addr, bus.inst_pc); else pass++;
    @(negedge clk);
    total++; if (bus.imem_addr !== 64'h4 || bus.inst_pc !== 64'h0) $display("FAIL wrap_next addr=%h pc=%h want 4/0", bus.imem_addr, bus.inst_pc); else pass++;
    #2 reset = 1;
    #1;
    total++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 64'h0) $display("FAIL areset_req req=%0b addr=%h want 0/0", bus.imem_req, bus.imem_addr); else pass++;
    total++; if (bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 || bus.inst_pc !== 64'h0) $display("FAIL areset_head valid=%0b inst=%h pc=%h want 0/0/0", bus.inst_valid, bus.inst, bus.inst_pc); else pass++;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_full();
    test_latency();
    test_drop();
    test_redirect_ack_pop();
    test_wrap_async_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
